// File: rtl/dmni_brlite_mon_writer_if.sv
// DMNI BrLite monitor writer memory port.
// Single-beat request/grant write channel.
interface dmni_brlite_mon_writer_if;
   logic        req;
   logic        gnt;
   logic [31:0] addr;
   logic [31:0] data;

   modport master (output req, output addr, output data, input gnt);
   modport slave  (input req, input addr, input data, output gnt);
endinterface

// File: rtl/dmni_brlite_mon_writer.sv
// DMNI BrLite monitor writer: per-service FIFOs feeding one
// round-robin memory write port into per-service PE tables.
module dmni_brlite_mon_writer #(
   parameter int  NSVC       = 2,
   parameter int  FIFO_DEPTH = 4,
   parameter int  N_PE_X     = 4,
   localparam int SW         = (NSVC > 1) ? $clog2(NSVC) : 1
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     cfg_ptr_we_i,
   input  logic [SW-1:0]            cfg_svc_i,
   input  logic [31:0]              cfg_ptr_i,
   input  logic                     clear_i,
   input  logic [NSVC-1:0]          clear_mask_i,
   input  logic                     mon_req_i,
   input  logic [64+SW-1:0]         mon_i,
   output logic                     mon_ack_o,
   dmni_brlite_mon_writer_if.master mem,
   output logic                     busy_o,
   output logic [15:0]              drop_cnt_o
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

   typedef struct packed {
      logic [31:0]   payload;
      logic [15:0]   seq_source;
      logic [15:0]   producer;
      logic [SW-1:0] msvc;
   } mon_t;

   typedef enum logic {IDLE, WRITE} state_t;

   mon_t            mon;
   logic [31:0]     ptr_q  [NSVC];
   logic [47:0]     fifo_q [NSVC][FIFO_DEPTH];
   logic [AW:0]     wptr_q [NSVC];
   logic [AW:0]     rptr_q [NSVC];
   logic [NSVC-1:0] empty;
   logic [NSVC-1:0] full;
   state_t          state_q;
   logic [SW-1:0]   rr_last_q;
   logic            mem_req_q;
   logic [31:0]     addr_q;
   logic [31:0]     data_q;
   logic [15:0]     drop_q;
   logic [15:0]     drop_d;

   assign mon = mon_t'(mon_i);

   always_comb begin
      for (int i = 0; i < NSVC; i++) begin
         empty[i] = (wptr_q[i] == rptr_q[i]);
         full[i]  = ((wptr_q[i] - rptr_q[i]) == DEPTH_C);
      end
   end

   logic svc_bad;
   logic clr_hit;
   logic push;
   logic ing_drop;

   assign svc_bad   = (32'(mon.msvc) >= 32'(NSVC));
   assign clr_hit   = clear_i & ~svc_bad & clear_mask_i[mon.msvc];
   assign mon_ack_o = mon_req_i & (svc_bad | ~full[mon.msvc] | clr_hit);
   assign push      = mon_ack_o & ~svc_bad & ~clr_hit;
   assign ing_drop  = mon_ack_o & (svc_bad | clr_hit);

   // First non-empty service after the last one served
   logic          pick_vld;
   logic [SW-1:0] pick_svc;
   int            j;

   always_comb begin
      pick_vld = 1'b0;
      pick_svc = '0;
      j        = 0;
      for (int i = 1; i <= NSVC; i++) begin
         j = (int'(rr_last_q) + i) % NSVC;
         if (!pick_vld && !empty[SW'(j)]) begin
            pick_vld = 1'b1;
            pick_svc = SW'(j);
         end
      end
   end

   logic        pop;
   logic        egr_drop;
   logic [47:0] pop_ent;
   logic [31:0] pop_ptr;
   logic [31:0] pop_idx;
   logic [16:0] drop_sum;

   assign pop      = (state_q == IDLE) & pick_vld;
   assign pop_ent  = fifo_q[pick_svc][rptr_q[pick_svc][AW-1:0]];
   assign pop_ptr  = ptr_q[pick_svc];
   assign egr_drop = pop & (pop_ptr == '0);
   // entry = {payload, producer}; producer = {x, y}
   assign pop_idx  = 32'(pop_ent[7:0]) * 32'(N_PE_X)
                   + 32'(pop_ent[15:8]);

   assign drop_sum = {1'b0, drop_q} + 17'(ing_drop) + 17'(egr_drop);
   assign drop_d   = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

   always_ff @(posedge clk_i) begin
      if (push)
         fifo_q[mon.msvc][wptr_q[mon.msvc][AW-1:0]] <=
            {mon.payload, mon.producer};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NSVC; i++) begin
            ptr_q[i]  <= '0;
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
         end
         state_q   <= IDLE;
         rr_last_q <= SW'(NSVC - 1);
         mem_req_q <= 1'b0;
         addr_q    <= '0;
         data_q    <= '0;
         drop_q    <= '0;
      end else begin
         drop_q <= drop_d;
         if (cfg_ptr_we_i && (32'(cfg_svc_i) < 32'(NSVC)))
            ptr_q[cfg_svc_i] <= cfg_ptr_i;
         for (int i = 0; i < NSVC; i++) begin
            if (push && (mon.msvc == SW'(i)))
               wptr_q[i] <= wptr_q[i] + 1'b1;
            if (clear_i && clear_mask_i[i])
               rptr_q[i] <= wptr_q[i];
            else if (pop && (pick_svc == SW'(i)))
               rptr_q[i] <= rptr_q[i] + 1'b1;
         end
         unique case (state_q)
            IDLE: begin
               if (pop) begin
                  rr_last_q <= pick_svc;
                  if (!egr_drop) begin
                     addr_q    <= pop_ptr + (pop_idx << 2);
                     data_q    <= pop_ent[47:16];
                     mem_req_q <= 1'b1;
                     state_q   <= WRITE;
                  end
               end
            end
            WRITE: begin
               if (mem.gnt) begin
                  mem_req_q <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign mem.req    = mem_req_q;
   assign mem.addr   = addr_q;
   assign mem.data   = data_q;
   assign busy_o     = ~(&empty) | (state_q != IDLE);
   assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_dmni_brlite_mon_writer.sv
// Scoreboard bench for dmni_brlite_mon_writer: expected writes
// are queued at stimulus time and popped by a memory-port monitor.
module tb_dmni_brlite_mon_writer;

   logic        clk = 1'b0;
   logic        rst_ni = 1'b1;
   logic        cfg_ptr_we = 1'b0;
   logic [0:0]  cfg_svc = '0;
   logic [31:0] cfg_ptr = '0;
   logic        clear = 1'b0;
   logic [1:0]  clear_mask = '0;
   logic        mon_req = 1'b0;
   logic [64:0] mon = '0;
   logic        mon_ack;
   logic        busy;
   logic [15:0] drop_cnt;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   dmni_brlite_mon_writer_if mif ();

   dmni_brlite_mon_writer #(
      .NSVC(2), .FIFO_DEPTH(4), .N_PE_X(4)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .cfg_ptr_we_i (cfg_ptr_we),
      .cfg_svc_i    (cfg_svc),
      .cfg_ptr_i    (cfg_ptr),
      .clear_i      (clear),
      .clear_mask_i (clear_mask),
      .mon_req_i    (mon_req),
      .mon_i        (mon),
      .mon_ack_o    (mon_ack),
      .mem          (mif),
      .busy_o       (busy),
      .drop_cnt_o   (drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted write must match the head of the queue
   always @(negedge clk) begin
      if (rst_ni && mif.req === 1'b1 && mif.gnt === 1'b1) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                     mif.addr, mif.data);
         end else begin
            mon_e = exp_q.pop_front();
            if ({mif.addr, mif.data} !== mon_e) begin
               n_fail++;
               $display("FAIL mem_write: got addr %0h data %0h expected addr %0h data %0h",
                        mif.addr, mif.data, mon_e[63:32], mon_e[31:0]);
            end
         end
      end
   end

   function automatic logic [64:0] mk(input logic svc,
                                      input logic [31:0] pl,
                                      input logic [15:0] prod);
      return {pl, 16'hBEEF, prod, svc};
   endfunction

   task automatic cfg(input logic svc, input logic [31:0] p);
      cfg_ptr_we = 1'b1;
      cfg_svc    = svc;
      cfg_ptr    = p;
      @(posedge clk); #1;
      cfg_ptr_we = 1'b0;
   endtask

   task automatic send(input logic svc, input logic [31:0] pl,
                       input logic [15:0] prod);
      bit got = 0;
      mon_req = 1'b1;
      mon     = mk(svc, pl, prod);
      for (int k = 0; k < 20 && !got; k++) begin
         @(negedge clk);
         got = mon_ack;
         @(posedge clk); #1;
      end
      mon_req = 1'b0;
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: got no ack expected ack for payload %0h", pl);
      end
   endtask

   task automatic wait_idle(input string name);
      bit done = 0;
      for (int k = 0; k < 60 && !done; k++) begin
         @(negedge clk);
         done = !busy;
      end
      @(posedge clk); #1;
      if (!done) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: got busy expected idle", name);
      end
   endtask

   initial begin
      mif.gnt = 1'b0;
      #2 rst_ni = 1'b0;
      @(negedge clk);
      check("rst_req",  32'(mif.req), 32'd0);
      check("rst_addr", mif.addr, 32'd0);
      check("rst_data", mif.data, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_drop", 32'(drop_cnt), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;

      // Basic write and latency
      cfg(1'b0, 32'h0000_1000);
      mif.gnt = 1'b1;
      exp_q.push_back({32'h0000_1024, 32'h0000_00A5});
      send(1'b0, 32'hA5, 16'h0102);
      @(negedge clk);
      check("lat_t1_req", 32'(mif.req), 32'd0);
      @(negedge clk);
      check("lat_t2_req", 32'(mif.req), 32'd1);
      @(posedge clk); #1;
      wait_idle("idle_basic");

      // Address wraps modulo 2^32
      cfg(1'b1, 32'hFFFF_FFF0);
      exp_q.push_back({32'h0000_002C, 32'h0000_005A});
      send(1'b1, 32'h5A, 16'h0303);
      wait_idle("idle_wrap");

      // Stall, fill, then round-robin drain
      cfg(1'b1, 32'h0000_2000);
      mif.gnt = 1'b0;
      exp_q.push_back({32'h0000_1000, 32'h11});
      exp_q.push_back({32'h0000_200C, 32'h21});
      exp_q.push_back({32'h0000_1010, 32'h12});
      exp_q.push_back({32'h0000_203C, 32'h22});
      exp_q.push_back({32'h0000_1038, 32'h13});
      exp_q.push_back({32'h0000_1014, 32'h14});
      exp_q.push_back({32'h0000_102C, 32'h15});
      send(1'b0, 32'h11, 16'h0000);
      send(1'b0, 32'h12, 16'h0001);
      send(1'b1, 32'h21, 16'h0300);
      send(1'b1, 32'h22, 16'h0303);
      send(1'b0, 32'h13, 16'h0203);
      send(1'b0, 32'h14, 16'h0101);
      send(1'b0, 32'h15, 16'h0302);
      mon_req = 1'b1;
      mon     = mk(1'b0, 32'h16, 16'h0000);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("full_ack", 32'(mon_ack), 32'd0);
         check("stall_req", 32'(mif.req), 32'd1);
         check("stall_addr", mif.addr, 32'h0000_1000);
         check("stall_data", mif.data, 32'h11);
      end
      @(posedge clk); #1;
      mon_req = 1'b0;
      check("full_drop", 32'(drop_cnt), 32'd0);
      mif.gnt = 1'b1;
      wait_idle("idle_rr");

      // Disabled service drops everything
      cfg(1'b1, 32'h0);
      send(1'b1, 32'h41, 16'h0000);
      send(1'b1, 32'h42, 16'h0101);
      send(1'b1, 32'h43, 16'h0202);
      wait_idle("idle_dis");
      check("dis_drop", 32'(drop_cnt), 32'd3);

      // Clear while a write is in flight
      mif.gnt = 1'b0;
      exp_q.push_back({32'h0000_1000, 32'h31});
      send(1'b0, 32'h31, 16'h0000);
      send(1'b0, 32'h32, 16'h0101);
      send(1'b0, 32'h33, 16'h0202);
      clear      = 1'b1;
      clear_mask = 2'b01;
      @(posedge clk); #1;
      clear      = 1'b0;
      clear_mask = 2'b00;
      @(negedge clk);
      check("clr_busy", 32'(busy), 32'd1);
      @(posedge clk); #1;
      mif.gnt = 1'b1;
      wait_idle("idle_clr");
      check("clr_drop", 32'(drop_cnt), 32'd3);

      // Push racing a clear on the same service
      mon_req    = 1'b1;
      mon        = mk(1'b0, 32'h44, 16'h0000);
      clear      = 1'b1;
      clear_mask = 2'b01;
      @(negedge clk);
      check("race_ack", 32'(mon_ack), 32'd1);
      @(posedge clk); #1;
      mon_req    = 1'b0;
      clear      = 1'b0;
      clear_mask = 2'b00;
      @(negedge clk);
      check("race_drop", 32'(drop_cnt), 32'd4);
      check("race_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;

      // Reset in the middle of a write
      mif.gnt = 1'b0;
      send(1'b0, 32'h55, 16'h0000);
      begin
         bit seen = 0;
         for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = mif.req;
         end
         check("rst_wait_req", 32'(seen), 32'd1);
      end
      #2 rst_ni = 1'b0;
      #1 check("rst_mid_req", 32'(mif.req), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_ni = 1'b1;
      check("rst2_drop", 32'(drop_cnt), 32'd0);
      check("rst2_addr", mif.addr, 32'd0);
      mif.gnt = 1'b1;
      send(1'b0, 32'h66, 16'h0101);
      wait_idle("idle_rst2");
      check("rst2_nowrite_drop", 32'(drop_cnt), 32'd1);

      repeat (3) @(posedge clk);
      check("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
